// File: rtl/digi_pkg.sv
// Shared definitions for the digitizer readout sequencer.
// Holds defaults, the FSM encoding, word field positions and the arbiter helper.
package digi_pkg;

  localparam int DEF_CHAN  = 8;
  localparam int DEF_WIDTH = 12;
  localparam int DEF_SIZE  = 8;
  localparam int DEF_CW    = $clog2(DEF_CHAN);

  localparam int CH_LSB    = DEF_WIDTH;
  localparam int FIRST_BIT = DEF_WIDTH + DEF_CW;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_NEXT  = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  // Highest pending channel is served first.
  function automatic logic [DEF_CW-1:0] top_bit(
    input logic [DEF_CHAN-1:0] v
  );
    top_bit = '0;
    for (int i = 0; i < DEF_CHAN; i++) begin
      if (v[i]) top_bit = i[DEF_CW-1:0];
    end
  endfunction

endpackage

// File: rtl/digi_out_fifo2.sv
// Two-entry output FIFO; the head entry drives the stream directly.
// Push and pop in the same cycle are allowed even when full.
module digi_out_fifo2 #(
  parameter int W = 17
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         valid,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wptr;
  logic         rptr;

  assign rdata = mem[rptr];
  assign valid = (count != 2'd0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/digi_readout_sched.sv
// End-of-spill readout sequencer: drains each flagged channel in turn
// and streams tagged words through a two-entry FIFO.
module digi_readout_sched
  import digi_pkg::*;
#(
  parameter int CHAN  = DEF_CHAN,
  parameter int WIDTH = DEF_WIDTH,
  parameter int SIZE  = DEF_SIZE,
  parameter int CW    = $clog2(CHAN),
  parameter int DW    = WIDTH + CW + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EOS,
  input  logic [CHAN-1:0]  DAVAIL,
  input  logic [SIZE-1:0]  howmany,
  input  logic [WIDTH-1:0] din,
  output logic [CHAN-1:0]  rd_request,
  output logic [CW-1:0]    rd_ch_sel,
  output logic [DW-1:0]    m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             busy,
  output logic             done,
  output logic             err_overrun
);

  state_t          state;
  state_t          state_nx;
  logic [CHAN-1:0] pending;
  logic [SIZE-1:0] cnt_max;
  logic [SIZE:0]   wcnt;
  logic [SIZE:0]   wcnt_inc;
  logic            first;
  logic            inflight;
  logic            last_pend;
  logic            issue;
  logic            last_issue;
  logic            pop;
  logic [1:0]      fcount;
  logic [2:0]      credit;
  logic [CHAN-1:0] sel_mask;
  logic [DW:0]     push_word;
  logic [DW:0]     head;

  assign sel_mask   = CHAN'(1) << rd_ch_sel;
  assign wcnt_inc   = wcnt + (SIZE+1)'(1);
  assign last_issue = (wcnt_inc == {1'b0, cnt_max});
  assign pop        = m_valid & m_ready;

  // An entry leaving the FIFO this cycle frees a slot for the next read.
  assign credit = {1'b0, fcount} + {2'b00, inflight}
                - {2'b00, pop};

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (EOS) state_nx = S_ARB;
      end
      S_ARB: begin
        if (pending == '0)
          state_nx = S_FIN;
        else if (cnt_max == '0)
          state_nx = S_NEXT;
        else
          state_nx = S_READ;
      end
      S_READ: begin
        if (credit < 3'd2) begin
          issue = 1'b1;
          if (last_issue) state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!inflight) state_nx = S_NEXT;
      end
      S_NEXT: begin
        state_nx = S_ARB;
      end
      S_FIN: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  assign rd_request = issue ? sel_mask : '0;
  assign done       = (state == S_FIN);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_IDLE;
      pending     <= '0;
      cnt_max     <= '0;
      wcnt        <= '0;
      first       <= 1'b0;
      inflight    <= 1'b0;
      last_pend   <= 1'b0;
      rd_ch_sel   <= '0;
      busy        <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state    <= state_nx;
      inflight <= issue;
      if (EOS && busy) err_overrun <= 1'b1;
      if (state == S_IDLE && EOS) begin
        pending <= DAVAIL;
        cnt_max <= howmany;
        busy    <= 1'b1;
      end
      if (state == S_ARB && pending != '0) begin
        rd_ch_sel <= top_bit(pending);
        wcnt      <= '0;
        first     <= 1'b1;
      end
      if (issue) begin
        wcnt      <= wcnt_inc;
        last_pend <= last_issue
                   && ((pending & ~sel_mask) == '0);
      end
      if (inflight) first <= 1'b0;
      if (state == S_NEXT) pending <= pending & ~sel_mask;
      if (state == S_FIN) busy <= 1'b0;
    end
  end

  // din is valid the cycle after the strobe, i.e. while inflight is set.
  assign push_word = {last_pend, first, rd_ch_sel, din};

  digi_out_fifo2 #(
    .W(DW + 1)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (inflight),
    .wdata (push_word),
    .pop   (pop),
    .rdata (head),
    .valid (m_valid),
    .count (fcount)
  );

  assign m_data = head[DW-1:0];
  assign m_last = m_valid & head[DW];

endmodule

// File: tb/tb_digi_readout_sched.sv
// Scoreboard bench for the readout sequencer with a behavioural channel array.
// Expected words are queued at EOS and checked by an independent monitor.
module tb_digi_readout_sched;
  import digi_pkg::*;

  localparam int CHAN  = 8;
  localparam int WIDTH = 12;
  localparam int SIZE  = 8;
  localparam int CW    = 3;
  localparam int DW    = 16;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             EOS = 1'b0;
  logic [CHAN-1:0]  DAVAIL = '0;
  logic [SIZE-1:0]  howmany = '0;
  logic [WIDTH-1:0] din = '0;
  logic [CHAN-1:0]  rd_request;
  logic [CW-1:0]    rd_ch_sel;
  logic [DW-1:0]    m_data;
  logic             m_valid;
  logic             m_ready = 1'b1;
  logic             m_last;
  logic             busy;
  logic             done;
  logic             err_overrun;

  always #5 CLK = ~CLK;

  digi_readout_sched #(
    .CHAN(CHAN), .WIDTH(WIDTH), .SIZE(SIZE)
  ) dut (
    .CLK(CLK), .RST(RST), .EOS(EOS),
    .DAVAIL(DAVAIL), .howmany(howmany), .din(din),
    .rd_request(rd_request), .rd_ch_sel(rd_ch_sel),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .busy(busy), .done(done),
    .err_overrun(err_overrun)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t sbq[$];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int spill = 0;
  int mode = 0;
  int idx[CHAN];
  int issued, accepted, n_rd, first_rd, last_rd;
  int first_valid, done_cnt;

  function automatic logic [WIDTH-1:0] sample(int ch, int i, int sp);
    int v;
    v = ch * 331 + i * 7 + sp * 53;
    return v[WIDTH-1:0];
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Channel array: data appears the cycle after each read strobe.
  initial begin : chan_model
    logic [CHAN-1:0] r;
    forever begin
      @(negedge CLK);
      r = rd_request;
      @(posedge CLK);
      #1;
      din = WIDTH'($urandom);
      for (int c = 0; c < CHAN; c++) begin
        if (r[c]) begin
          din = sample(c, idx[c], spill);
          idx[c]++;
        end
      end
    end
  end

  initial begin : ready_gen
    int ph;
    ph = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (mode == 0) m_ready = 1'b1;
      else begin
        m_ready = (ph == 0);
        ph = (ph + 1) % 3;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (rd_request != '0) begin
          check("rd_onehot", 32'(rd_request),
                32'(CHAN'(1) << rd_ch_sel));
          if (first_rd < 0) first_rd = cyc;
          last_rd = cyc;
          n_rd++;
          issued++;
        end
        if (m_valid && first_valid < 0) first_valid = cyc;
        if (m_valid && m_ready) begin
          accepted++;
          if (sbq.size() == 0) begin
            check("extra_word", 32'(m_data), 32'hFFFF_FFFF);
          end else begin
            e = sbq.pop_front();
            check("m_data", 32'(m_data), 32'(e.data));
            check("m_last", 32'(m_last), 32'(e.last));
          end
        end
        if (rd_request != '0)
          check("outstanding_le2", 32'(issued - accepted <= 2), 1);
        if (done) done_cnt++;
      end
    end
  end

  task automatic expect_spill(logic [CHAN-1:0] dav, int hm);
    int nch;
    int k;
    nch = $countones(dav);
    k = 0;
    for (int c = CHAN - 1; c >= 0; c--) begin
      if (dav[c]) begin
        k++;
        for (int w = 0; w < hm; w++) begin
          exp_t e;
          e.data = '0;
          e.data[FIRST_BIT] = (w == 0);
          e.data[CH_LSB +: CW] = c[CW-1:0];
          e.data[WIDTH-1:0] = sample(c, w, spill);
          e.last = (k == nch) && (w == hm - 1);
          sbq.push_back(e);
        end
      end
    end
  endtask

  task automatic run_spill(logic [CHAN-1:0] dav, int hm,
                           output int eos_cyc);
    spill++;
    for (int c = 0; c < CHAN; c++) idx[c] = 0;
    issued = 0; accepted = 0; n_rd = 0;
    first_rd = -1; last_rd = -1;
    first_valid = -1; done_cnt = 0;
    expect_spill(dav, hm);
    @(posedge CLK);
    #1;
    DAVAIL = dav;
    howmany = SIZE'(hm);
    EOS = 1'b1;
    eos_cyc = cyc;
    @(posedge CLK);
    #1;
    EOS = 1'b0;
    DAVAIL = CHAN'($urandom);
    howmany = SIZE'($urandom);
  endtask

  task automatic wait_done(int budget, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (done) begin
        dcyc = cyc;
        break;
      end
    end
    if (dcyc < 0) check("done_timeout", 0, 1);
  endtask

  task automatic wait_empty(string name, int budget);
    int ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (sbq.size() == 0) begin
        ok = 1;
        break;
      end
      @(negedge CLK);
    end
    check({name, "_all_words"}, 32'(ok), 1);
    repeat (4) @(negedge CLK);
    check({name, "_done_once"}, 32'(done_cnt), 1);
    check({name, "_busy_idle"}, 32'(busy), 0);
    check({name, "_valid_idle"}, 32'(m_valid), 0);
  endtask

  initial begin : stim
    int e;
    int d;
    int seen;

    #2 RST = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_rd_request", 32'(rd_request), 0);
    check("rst_rd_ch_sel", 32'(rd_ch_sel), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_m_last", 32'(m_last), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err_overrun), 0);
    @(posedge CLK);
    #1 RST = 1'b0;
    repeat (2) @(posedge CLK);

    // basic drain: channels 7, 2, 0 with three words each
    run_spill(8'b1000_0101, 3, e);
    wait_done(200, d);
    check("basic_done_cyc", 32'(d - e), 23);
    check("basic_first_rd", 32'(first_rd - e), 2);
    check("basic_first_valid", 32'(first_valid - e), 4);
    wait_empty("basic", 50);
    check("basic_nrd", 32'(n_rd), 9);

    // backpressure on a single channel
    mode = 1;
    run_spill(8'b0010_0000, 10, e);
    wait_done(300, d);
    wait_empty("bp", 200);
    check("bp_nrd", 32'(n_rd), 10);
    mode = 0;

    // nothing flagged
    run_spill(8'h00, 3, e);
    wait_done(50, d);
    check("empty_done_cyc", 32'(d - e), 2);
    wait_empty("empty", 10);
    check("empty_nrd", 32'(n_rd), 0);
    check("empty_novalid", 32'(first_valid), 32'hFFFF_FFFF);

    // all flagged, zero words each
    run_spill(8'hFF, 0, e);
    wait_done(100, d);
    check("zero_done_cyc", 32'(d - e), 18);
    wait_empty("zero", 10);
    check("zero_nrd", 32'(n_rd), 0);
    check("zero_novalid", 32'(first_valid), 32'hFFFF_FFFF);

    // second EOS during READ
    run_spill(8'b0100_0001, 6, e);
    repeat (2) @(posedge CLK);
    #1;
    DAVAIL = 8'hFF;
    howmany = 8'd9;
    EOS = 1'b1;
    @(posedge CLK);
    #1 EOS = 1'b0;
    @(negedge CLK);
    check("ovr_err_set", 32'(err_overrun), 1);
    wait_done(200, d);
    wait_empty("ovr", 50);
    repeat (10) @(negedge CLK);
    check("ovr_nrd", 32'(n_rd), 12);
    check("ovr_no_restart", 32'(busy), 0);
    check("ovr_err_sticky", 32'(err_overrun), 1);

    // asynchronous reset while channel 3 is being read
    run_spill(8'b0000_1000, 20, e);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (rd_request[3]) begin
        seen = 1;
        break;
      end
    end
    check("rst_mid_reading", 32'(seen), 1);
    #2 RST = 1'b1;
    #1;
    check("rst_mid_rd_request", 32'(rd_request), 0);
    check("rst_mid_m_valid", 32'(m_valid), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_err", 32'(err_overrun), 0);
    sbq.delete();
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (2) @(posedge CLK);
    run_spill(8'b0000_1000, 4, e);
    wait_done(100, d);
    check("post_rst_first_valid", 32'(first_valid - e), 4);
    wait_empty("post_rst", 50);
    check("post_rst_nrd", 32'(n_rd), 4);

    // maximum count on channel 1
    run_spill(8'b0000_0010, 255, e);
    wait_done(1000, d);
    wait_empty("max", 50);
    check("max_nrd", 32'(n_rd), 255);
    check("max_contig", 32'(last_rd - first_rd + 1), 255);
    check("max_first_rd", 32'(first_rd - e), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
